// File: rtl/ds_frame_packer.sv
// Rounds/saturates accumulated sums, buffers them and emits sync/seq/payload frames.
// Define DS_FRAME_CHECKSUM_EN to append an XOR checksum word to every frame.
module ds_frame_packer #(
    parameter int          DATA_WIDTH  = 14,
    parameter int          SAMPLE_RATE = 4,
    parameter int          FIFO_DEPTH  = 512,
    parameter int          FRAME_LEN   = 64,
    parameter logic [15:0] SYNC_WORD   = 16'hA5A5
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [DATA_WIDTH+SAMPLE_RATE-1:0] in_data,
    input  logic                              in_valid,
    output logic [15:0]                       out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow
);
    localparam int SW = DATA_WIDTH + SAMPLE_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [SW:0]    ONE      = {{SW{1'b0}}, 1'b1};
    localparam logic [SW:0]    HALF     = ONE << (SAMPLE_RATE - 1);
    localparam logic [LW-1:0]  DEPTH    = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]  FLEN     = LW'(FRAME_LEN);
    localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_LEN - 1);

`ifdef DS_FRAME_CHECKSUM_EN
    localparam bit PAY_LAST = 1'b0;
    typedef enum logic [2:0] {IDLE, HDR, SEQ, PAY, CSUM} state_t;
    logic [15:0] csum;
`else
    localparam bit PAY_LAST = 1'b1;
    typedef enum logic [1:0] {IDLE, HDR, SEQ, PAY} state_t;
`endif

    state_t                state;
    logic [SW:0]           rnd;
    logic [DATA_WIDTH:0]   avg_w;
    logic [DATA_WIDTH-1:0] avg_s;
    logic [15:0]           avg_q;
    logic                  avg_v;
    logic [15:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         cnt;
    logic [15:0]           seq;
    logic                  xfer;
    logic                  pop;
    logic                  push;

    // Round half up at full width, then clamp to the output range.
    assign rnd   = {1'b0, in_data} + HALF;
    assign avg_w = rnd[SW:SAMPLE_RATE];
    assign avg_s = avg_w[DATA_WIDTH] ? '1 : avg_w[DATA_WIDTH-1:0];

    assign xfer = out_valid && out_ready;
    assign pop  = xfer && (state == PAY);
    assign push = avg_v && ((fifo_level < DEPTH) || pop);

    always_ff @(posedge clk_in) begin
        if (push) mem[wptr] <= avg_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            avg_q      <= '0;
            avg_v      <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            cnt        <= '0;
            seq        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
`ifdef DS_FRAME_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            avg_v <= in_valid;
            if (in_valid) avg_q <= 16'(avg_s);
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (avg_v && !push) overflow <= 1'b1;

            unique case (state)
                IDLE: begin
                    // A full frame must be buffered so the payload never underruns.
                    if (fifo_level >= FLEN) begin
                        state     <= HDR;
                        out_valid <= 1'b1;
                        out_data  <= SYNC_WORD;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state    <= SEQ;
                        out_data <= seq;
                    end
                end
                SEQ: begin
                    if (xfer) begin
                        state    <= PAY;
                        out_data <= mem[rptr];
                        cnt      <= '0;
                        out_last <= PAY_LAST && (FRAME_LEN == 1);
`ifdef DS_FRAME_CHECKSUM_EN
                        csum     <= seq;
`endif
                    end
                end
                PAY: begin
                    if (xfer) begin
                        if (cnt == LAST_IDX) begin
                            seq <= seq + 16'd1;
`ifdef DS_FRAME_CHECKSUM_EN
                            state    <= CSUM;
                            out_data <= csum ^ out_data;
                            out_last <= 1'b1;
`else
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
`endif
                        end else begin
                            out_data <= mem[rptr + AW'(1)];
                            cnt      <= cnt + CW'(1);
                            out_last <= PAY_LAST && ((cnt + CW'(1)) == LAST_IDX);
`ifdef DS_FRAME_CHECKSUM_EN
                            csum     <= csum ^ out_data;
`endif
                        end
                    end
                end
`ifdef DS_FRAME_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ds_frame_packer.sv
// Bench for ds_frame_packer: stream scoreboard plus directed frame checks.
module tb_ds_frame_packer;
    localparam int DW   = 14;
    localparam int SR   = 4;
    localparam int FD   = 8;
    localparam int FLEN = 4;
`ifdef DS_FRAME_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
    localparam int FL = FLEN + 3;
`else
    localparam bit CSUM_ON = 1'b0;
    localparam int FL = FLEN + 2;
`endif

    logic          clk;
    logic          rst_in;
    logic [DW+SR-1:0] in_data;
    logic          in_valid;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [3:0]    fifo_level;
    logic          overflow;

    ds_frame_packer #(
        .DATA_WIDTH (DW),
        .SAMPLE_RATE(SR),
        .FIFO_DEPTH (FD),
        .FRAME_LEN  (FLEN),
        .SYNC_WORD  (16'hA5A5)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: average as plain arithmetic.
    function automatic logic [15:0] avg_m(input logic [DW+SR-1:0] x);
        longint unsigned v;
        v = (longint'(x) + (2 ** (SR - 1))) / (2 ** SR);
        if (v > (2 ** DW) - 1) v = (2 ** DW) - 1;
        return 16'(v);
    endfunction

    logic [15:0] q[$];
    logic [16:0] log_q[$];
    int          occ;
    bit          ovf_m;
    int          pos;
    logic [15:0] seq_m;
    logic [15:0] csum_m;
    bit          pend_v;
    logic [15:0] pend_w;
    bit          pop_now;
    bit          prev_stall;
    logic [15:0] prev_d;
    logic        prev_l;
    logic [15:0] ew;
    logic        el;

    always @(negedge clk) begin
        if (!rst_in) begin
            q.delete();
            occ = 0; ovf_m = 0; pos = 0; seq_m = '0; csum_m = '0;
            pend_v = 0; pend_w = '0; prev_stall = 0;
        end else begin
            chk("level", 32'(fifo_level), 32'(occ));
            chk("overflow", 32'(overflow), 32'(ovf_m));
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(prev_d));
                chk("hold_last", 32'(out_last), 32'(prev_l));
            end
            pop_now = 0;
            if (out_valid && out_ready) begin
                el = 1'b0;
                ew = '0;
                if (pos == 0) begin
                    ew = 16'hA5A5;
                end else if (pos == 1) begin
                    ew = seq_m;
                    csum_m = seq_m;
                end else if (pos <= FLEN + 1) begin
                    chk("pay_avail", 32'(q.size() != 0), 1);
                    if (q.size() != 0) ew = q.pop_front();
                    pop_now = 1;
                    csum_m = csum_m ^ ew;
                    el = (pos == FLEN + 1) && !CSUM_ON;
                end else begin
                    ew = csum_m;
                    el = 1'b1;
                end
                chk("word", 32'(out_data), 32'(ew));
                chk("last", 32'(out_last), 32'(el));
                log_q.push_back({out_last, out_data});
                if (el) begin
                    pos = 0;
                    seq_m = seq_m + 16'd1;
                end else begin
                    pos++;
                end
            end
            if (pend_v) begin
                if (occ < FD || pop_now) begin
                    q.push_back(pend_w);
                    occ++;
                end else begin
                    ovf_m = 1;
                end
            end
            if (pop_now) occ--;
            pend_v = in_valid;
            pend_w = avg_m(in_data);
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [DW+SR-1:0] x);
        in_data = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (log_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk("wait_words", 32'(log_q.size() >= n), 1);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        log_q.delete();
    endtask

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_in = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        tick();

        // Rounding and saturation
        sample(16); sample(24); sample(7); sample(262143);
        wait_words(FL, 100);
        chk("t1_sync", 32'(log_q[0][15:0]), 'hA5A5);
        chk("t1_seq", 32'(log_q[1][15:0]), 'h0000);
        chk("t1_p0", 32'(log_q[2][15:0]), 'h0001);
        chk("t1_p1", 32'(log_q[3][15:0]), 'h0002);
        chk("t1_p2", 32'(log_q[4][15:0]), 'h0000);
        chk("t1_p3", 32'(log_q[5][15:0]), 'h3FFF);

        // Basic frame from fresh reset
        do_reset();
        for (int k = 1; k <= 4; k++) sample(18'(16 * k));
        wait_words(FL, 100);
        chk("t2_sync", 32'(log_q[0][15:0]), 'hA5A5);
        chk("t2_seq", 32'(log_q[1][15:0]), 'h0000);
        for (int i = 0; i < 4; i++)
            chk("t2_pay", 32'(log_q[2+i][15:0]), 32'(i + 1));
        for (int i = 0; i < FL; i++)
            chk("t2_last", 32'(log_q[i][16]), 32'(i == FL - 1));
`ifdef DS_FRAME_CHECKSUM_EN
        chk("t6_csum", 32'(log_q[FL-1][15:0]), 'h0004);
`endif

        // Backpressure on the following frame
        repeat (3) tick();
        log_q.delete();
        for (int k = 5; k <= 8; k++) sample(18'(16 * k));
        for (int c = 0; c < 200 && log_q.size() < FL; c++) begin
            out_ready = pat[c % 4];
            tick();
        end
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t3_count", 32'(log_q.size()), 32'(FL));
        chk("t3_seq", 32'(log_q[1][15:0]), 'h0001);
        for (int i = 0; i < 4; i++)
            chk("t3_pay", 32'(log_q[2+i][15:0]), 32'(i + 5));

        // Overflow with the sink stalled
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) sample(18'(16 * k));
        repeat (3) tick();
        chk("t4_level", 32'(fifo_level), 8);
        chk("t4_ovf", 32'(overflow), 1);
        out_ready = 1'b1;
        wait_words(2 * FL, 200);
        repeat (5) tick();
        chk("t4_count", 32'(log_q.size()), 32'(2 * FL));
        chk("t4_seq0", 32'(log_q[1][15:0]), 'h0000);
        chk("t4_seq1", 32'(log_q[FL+1][15:0]), 'h0001);
        for (int i = 0; i < 4; i++) begin
            chk("t4_pay0", 32'(log_q[2+i][15:0]), 32'(i + 1));
            chk("t4_pay1", 32'(log_q[FL+2+i][15:0]), 32'(i + 5));
        end
        chk("t4_idle", 32'(out_valid), 0);
        chk("t4_ovf_sticky", 32'(overflow), 1);
        chk("t4_empty", 32'(fifo_level), 0);

        // Reset in the middle of a payload
        log_q.delete();
        for (int k = 1; k <= 4; k++) sample(18'(16 * k));
        wait_words(3, 100);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        @(negedge clk);
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_level", 32'(fifo_level), 0);
        chk("t5_ovf", 32'(overflow), 0);
        tick();
        log_q.delete();
        for (int k = 1; k <= 4; k++) sample(18'(16 * k));
        wait_words(FL, 100);
        chk("t5_sync", 32'(log_q[0][15:0]), 'hA5A5);
        chk("t5_seq", 32'(log_q[1][15:0]), 'h0000);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
